// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and drives the IF/ID register.
// Ports: clk, rst, stall, redirect(_pc), imem_* handshake, if_* bundle, pc, halted.
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic        ifid_en,
    output logic [15:0] if_instr,
    output logic [15:0] if_nextpc,
    output logic        if_flush,
    output logic [15:0] pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        BUF   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nx;
    logic [15:0] r_buf;
    logic [15:0] w_buf_nx;
    logic [15:0] w_pc2;
    logic [15:0] w_rpc;

    assign w_pc2     = r_pc + 16'd2;
    assign w_rpc     = {redirect_pc[15:1], 1'b0};
    assign pc        = r_pc;
    assign imem_addr = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_buf   <= NOP_INSTR;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_buf   <= w_buf_nx;
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        ifid_en    = 1'b0;
        if_flush   = 1'b0;
        if_instr   = NOP_INSTR;
        if_nextpc  = w_pc2;
        halted     = 1'b0;
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_buf_nx   = r_buf;
        if (rst) begin
            if_nextpc = RESET_PC + 16'd2;
        end else if (redirect) begin
            // Squash whatever is in flight; any response this cycle is dropped.
            ifid_en    = 1'b1;
            if_flush   = 1'b1;
            if_nextpc  = w_rpc;
            halted     = (r_state == HALT);
            w_state_nx = FETCH;
            w_pc_nx    = w_rpc;
            w_buf_nx   = NOP_INSTR;
        end else begin
            unique case (r_state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_valid && !stall) begin
                        ifid_en  = 1'b1;
                        if_instr = imem_rdata;
                        w_pc_nx  = w_pc2;
                        if (imem_rdata[15:12] == HLT_OPCODE)
                            w_state_nx = HALT;
                    end else if (imem_valid) begin
                        // Decode busy: park the word so the request can retire.
                        w_buf_nx   = imem_rdata;
                        w_state_nx = BUF;
                    end
                end
                BUF: begin
                    if_instr = r_buf;
                    if (!stall) begin
                        ifid_en    = 1'b1;
                        w_pc_nx    = w_pc2;
                        w_state_nx = (r_buf[15:12] == HLT_OPCODE) ? HALT : FETCH;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    w_state_nx = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Drives inputs 1ns after posedge, samples outputs on negedge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        ifid_en;
    logic [15:0] if_instr;
    logic [15:0] if_nextpc;
    logic        if_flush;
    logic [15:0] pc;
    logic        halted;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .ifid_en    (ifid_en),
        .if_instr   (if_instr),
        .if_nextpc  (if_nextpc),
        .if_flush   (if_flush),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rd,
                         input logic [15:0] rp, input logic v,
                         input logic [15:0] d);
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rp;
        imem_valid  = v;
        imem_rdata  = d;
    endtask

    task automatic to_neg;
        @(negedge clk);
    endtask

    task automatic to_pos;
        @(posedge clk);
        #1;
    endtask

    task automatic out_chk(input string tag, input logic req,
                           input logic en, input logic fl,
                           input logic [15:0] ins, input logic [15:0] npc);
        chk({tag, ".req"}, {15'd0, imem_req}, {15'd0, req});
        chk({tag, ".en"}, {15'd0, ifid_en}, {15'd0, en});
        chk({tag, ".flush"}, {15'd0, if_flush}, {15'd0, fl});
        if (en) begin
            chk({tag, ".instr"}, if_instr, ins);
            chk({tag, ".npc"}, if_nextpc, npc);
        end
    endtask

    initial begin
        logic [15:0] words [3];
        words[0] = 16'h1234;
        words[1] = 16'h2345;
        words[2] = 16'h3456;

        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        to_pos;
        to_neg;
        out_chk("rst", 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("rst.instr", if_instr, 16'h0000);
        chk("rst.npc", if_nextpc, 16'h0002);
        chk("rst.halt", {15'd0, halted}, 16'd0);
        to_pos;
        chk("rst.pc", pc, 16'h0000);

        // zero-wait stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, words[i]);
            to_neg;
            chk("zw.addr", imem_addr, 16'(2 * i));
            out_chk("zw", 1'b1, 1'b1, 1'b0, words[i], 16'(2 * i + 2));
            to_pos;
            chk("zw.pc", pc, 16'(2 * i + 2));
        end

        // 3-cycle latency at 0x0006
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'hDEAD);
            to_neg;
            chk("lat.addr", imem_addr, 16'h0006);
            out_chk("lat.wait", 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
            to_pos;
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h4567);
        to_neg;
        out_chk("lat.hit", 1'b1, 1'b1, 1'b0, 16'h4567, 16'h0008);
        to_pos;
        chk("lat.pc", pc, 16'h0008);

        // stall on arrival, held 2 cycles
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hABCD);
        to_neg;
        out_chk("st.arr", 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        to_pos;
        chk("st.pc0", pc, 16'h0008);
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h9999);
        to_neg;
        out_chk("st.buf", 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("st.bufins", if_instr, 16'hABCD);
        to_pos;
        chk("st.pc1", pc, 16'h0008);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        to_neg;
        out_chk("st.rel", 1'b0, 1'b1, 1'b0, 16'hABCD, 16'h000A);
        to_pos;
        chk("st.pc2", pc, 16'h000A);

        // redirect while in BUF
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h5555);
        to_pos;
        drive(1'b0, 1'b1, 1'b1, 16'h0041, 1'b0, 16'h0);
        to_neg;
        out_chk("rd.buf", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0040);
        to_pos;
        chk("rd.pc", pc, 16'h0040);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
        to_neg;
        chk("rd.addr", imem_addr, 16'h0040);
        out_chk("rd.fetch", 1'b1, 1'b1, 1'b0, 16'h1111, 16'h0042);
        to_pos;
        chk("rd.pc2", pc, 16'h0042);

        // redirect drops a concurrent response
        drive(1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h7777);
        to_neg;
        out_chk("rd.drop", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0010);
        to_pos;
        chk("rd.pc3", pc, 16'h0010);

        // HLT at 0x0010
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hF000);
        to_neg;
        out_chk("hlt.del", 1'b1, 1'b1, 1'b0, 16'hF000, 16'h0012);
        chk("hlt.h0", {15'd0, halted}, 16'd0);
        to_pos;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h2222);
        to_neg;
        chk("hlt.h1", {15'd0, halted}, 16'd1);
        out_chk("hlt.idle", 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        to_pos;
        chk("hlt.pc", pc, 16'h0012);
        drive(1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0);
        to_pos;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h2222);
        to_neg;
        chk("hlt.clr", {15'd0, halted}, 16'd0);
        chk("hlt.addr", imem_addr, 16'h0100);
        out_chk("hlt.resume", 1'b1, 1'b1, 1'b0, 16'h2222, 16'h0102);
        to_pos;
        chk("hlt.pc2", pc, 16'h0102);

        // PC wrap
        drive(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0);
        to_pos;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h3333);
        to_neg;
        out_chk("wrap", 1'b1, 1'b1, 1'b0, 16'h3333, 16'h0000);
        to_pos;
        chk("wrap.pc", pc, 16'h0000);

        // reset mid-wait with late response
        drive(1'b0, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0);
        to_pos;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        to_neg;
        out_chk("mw.wait", 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        to_pos;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h7777);
        to_neg;
        out_chk("mw.rst", 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("mw.npc", if_nextpc, 16'h0002);
        to_pos;
        chk("mw.pc", pc, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        to_neg;
        chk("mw.addr", imem_addr, 16'h0000);
        out_chk("mw.after", 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        to_pos;
        chk("mw.pc2", pc, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit pipeline; it is the writer side of the IF/ID pipeline register.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Delivers {instruction, PC+2, flush} to IF/ID using a single-cycle write-enable (ifid_en).
- Absorbs decode stalls with a one-entry holding buffer; handles branch/jump redirects by injecting a flushed bubble; stops on HLT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OPCODE, 4'hF, instr[15:12] value that halts fetch.
- NOP_INSTR, 16'h0000, instruction word driven on bubbles and idle cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; decode cannot accept a new word this cycle.
- redirect  input  1  taken branch/jump resolved downstream.
- redirect_pc  input  16  redirect target; bit 0 ignored (forced 0).
- imem_req  output  1  fetch request, level; held until imem_valid.
- imem_addr  output  16  fetch address (= pc).
- imem_rdata  input  16  instruction word; sampled only when imem_valid & imem_req.
- imem_valid  input  1  one-cycle data-valid strobe from memory.
- ifid_en  output  1  write-enable to IF/ID register.
- if_instr  output  16  instruction toward IF/ID.
- if_nextpc  output  16  PC+2 of the delivered instruction.
- if_flush  output  1  marks the delivered word as a squashed bubble.
- pc  output  16  current fetch PC.
- halted  output  1  fetch stopped on HLT.

Behaviour:
- Registered state: pc, state {FETCH, BUF, HALT}, buf_instr[15:0]. All IF/ID-side outputs and imem_req are combinational from state and inputs.
- Reset (rst=1 at edge): pc=RESET_PC, state=FETCH, buf_instr=NOP_INSTR.
- While rst=1, outputs are forced to: imem_req=0, ifid_en=0, if_flush=0, halted=0, if_instr=NOP_INSTR, if_nextpc=RESET_PC+2.
- First request is driven in the first cycle after rst deasserts.
- PC arithmetic: pc+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000. pc[0] is always 0.
- Priority order: rst > redirect > normal operation.
- Redirect (any state):
  - Same cycle: imem_req=0, ifid_en=1, if_flush=1, if_instr=NOP_INSTR, if_nextpc=redirect_pc. This overrides stall.
  - Next edge: pc<=redirect_pc, state<=FETCH, buf discarded.
  - A memory response arriving in the redirect cycle is discarded.
- FETCH: imem_req=1, imem_addr=pc.
  - No imem_valid: ifid_en=0, state unchanged.
  - imem_valid & !stall: ifid_en=1, if_instr=imem_rdata, if_nextpc=pc+2, pc<=pc+2. Next state is HALT if imem_rdata[15:12]==HLT_OPCODE, else FETCH, so back-to-back fetch is possible at zero-wait memory.
  - imem_valid & stall: ifid_en=0, buf_instr<=imem_rdata, state<=BUF, pc unchanged.
- BUF: imem_req=0, if_instr=buf_instr, if_nextpc=pc+2.
  - stall: ifid_en=0, hold.
  - !stall: ifid_en=1, pc<=pc+2. Next state is HALT if buf_instr[15:12]==HLT_OPCODE, else FETCH.
- HALT: imem_req=0, ifid_en=0, halted=1, pc holds the address after the HLT.
  - Exit only via redirect (speculative HLT squashed) or rst.
- if_flush=1 only in redirect cycles. ifid_en=0 in all idle, wait and stall cycles.
- Memory contract: at most one outstanding request. A request withdrawn (imem_req low) before imem_valid is abandoned. imem_valid without imem_req is ignored.

Test Plan:
- Reset then zero-wait memory returning 16'h1234, 16'h2345, … from 0x0000: ifid_en=1 every cycle; if_nextpc=0x0002, 0x0004, …; pc increments by 2 per cycle.
- 3-cycle memory latency: imem_req stays high with a stable address for 3 cycles; ifid_en pulses once per word, 0 in wait cycles.
- Stall asserted in the cycle imem_valid arrives with 16'hABCD, held 2 cycles: state BUF, ifid_en=0, imem_req=0. On release: ifid_en=1, if_instr=16'hABCD, pc advances by exactly 2, no word lost or duplicated.
- Redirect to 0x0041 while stalled in BUF:
  - Redirect cycle: ifid_en=1, if_flush=1, if_instr=NOP_INSTR, buffer dropped.
  - Next edge: pc=0x0040, then fetch resumes at 0x0040.
- Fetch 16'hF000 at 0x0010: ifid_en=1 with the HLT word; then halted=1, imem_req=0, pc=0x0012. A later redirect to 0x0100 clears halted and fetches 0x0100.
- PC at 0xFFFE with a normal instruction: if_nextpc=0x0000 and pc wraps to 0x0000. rst asserted mid-wait: next cycle pc=RESET_PC, and the late imem_valid is ignored.
